// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson shift-register sequence counter.
// Supports a runtime mode and direction, enable, parallel load, illegal-state
// self-correction, and a one-cycle wrap pulse when the sequence returns to the seed.
module ring_johnson_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             illegal,
  output logic             wrap
);

  localparam int unsigned    CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SEED  = WIDTH'(1);

  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] edges;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Population count and adjacent-bit transition count of the current state
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones = ones + CNT_W'(q[i]);
    end
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      edges = edges + CNT_W'(q[i] ^ q[i+1]);
    end
  end

  // Legality: ring needs exactly one hot bit; Johnson allows at most one transition
  always_comb begin
    illegal = 1'b0;
    if (mode) begin
      illegal = (edges > CNT_W'(1));
    end else begin
      illegal = (ones != CNT_W'(1));
    end
  end

  // One step of the sequence for the selected mode and direction
  always_comb begin
    stepped = q;
    case ({mode, dir})
      2'b00:   stepped = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b01:   stepped = {q[0], q[WIDTH-1:1]};
      2'b10:   stepped = {q[WIDTH-2:0], ~q[WIDTH-1]};
      2'b11:   stepped = {~q[0], q[WIDTH-1:1]};
      default: stepped = q;
    endcase
  end

  // Next state in priority order: load, self-correct, step, hold
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = load_val;
    end else if (en) begin
      if (illegal) begin
        q_nxt = SEED;
      end else begin
        q_nxt    = stepped;
        wrap_nxt = (stepped == SEED);
      end
    end
  end

  // State and wrap registers; reset returns to the seed immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= SEED;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Self-checking bench for ring_johnson_counter (WIDTH=4 and WIDTH=8 instances).
// The reference model views each mode as an ordered table of legal states and
// moves an index through it, rather than shifting bits.
module tb_ring_johnson_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [7:0] load_val;

  logic [3:0] q4;
  logic       illegal4;
  logic       wrap4;
  logic [7:0] q8;
  logic       illegal8;
  logic       wrap8;

  logic [7:0] m4;
  logic       mw4;
  logic [7:0] m8;
  logic       mw8;

  int tests;
  int fails;

  ring_johnson_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val[3:0]), .q(q4), .illegal(illegal4), .wrap(wrap4)
  );

  ring_johnson_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q8), .illegal(illegal8), .wrap(wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k-th legal state of the sequence; index 0 is the seed's predecessor in Johnson
  function automatic logic [7:0] seq_val(input logic md, input int k, input int w);
    logic [8:0] full;
    full = (9'd1 << w) - 9'd1;
    if (!md) return 8'(9'd1 << k);
    if (k <= w) return 8'((9'd1 << k) - 9'd1);
    return 8'(full) & ~8'((9'd1 << (k - w)) - 9'd1);
  endfunction

  function automatic int seq_len(input logic md, input int w);
    return md ? 2 * w : w;
  endfunction

  // Position of v in the legal sequence, or -1 if v is not a legal state
  function automatic int phase_of(input logic [7:0] v, input logic md, input int w);
    for (int k = 0; k < seq_len(md, w); k++) begin
      if (seq_val(md, k, w) == v) return k;
    end
    return -1;
  endfunction

  // Returns {wrap, q} after one clock
  function automatic logic [8:0] model_next(input logic [7:0] cur, input int w,
                                            input logic ld, input logic [7:0] lv,
                                            input logic e, input logic md, input logic dr);
    logic [7:0] mask;
    logic [7:0] v;
    int p;
    int n;
    mask = 8'((9'd1 << w) - 9'd1);
    if (ld) return {1'b0, lv & mask};
    if (!e) return {1'b0, cur};
    p = phase_of(cur, md, w);
    if (p < 0) return {1'b0, 8'd1};
    n = seq_len(md, w);
    v = seq_val(md, dr ? (p + n - 1) % n : (p + 1) % n, w);
    return {v == 8'd1, v};
  endfunction

  // Reference model state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4  <= 8'd1;
      mw4 <= 1'b0;
      m8  <= 8'd1;
      mw8 <= 1'b0;
    end else begin
      {mw4, m4} <= model_next(m4, 4, load, load_val, en, mode, dir);
      {mw8, m8} <= model_next(m8, 8, load, load_val, en, mode, dir);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("q4", 8'(q4), m4);
    chk("wrap4", 8'(wrap4), 8'(mw4));
    chk("illegal4", 8'(illegal4), 8'(phase_of(m4, mode, 4) < 0));
    chk("q8", q8, m8);
    chk("wrap8", 8'(wrap8), 8'(mw8));
    chk("illegal8", 8'(illegal8), 8'(phase_of(m8, mode, 8) < 0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_j [8];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    dir = 1'b0;
    load = 1'b0;
    load_val = 8'd0;
    exp_j = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

    // Reset then idle
    #12 rst_n = 1'b1;
    repeat (3) cyc();
    chk("rst_q4", 8'(q4), 8'b0001);
    chk("rst_wrap4", 8'(wrap4), 8'd0);
    chk("rst_illegal4", 8'(illegal4), 8'd0);

    // Ring left, 8 steps (both widths)
    en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("ringl_q4", 8'(q4), 8'(9'd1 << (c % 4)));
      chk("ringl_wrap4", 8'(wrap4), 8'(c % 4 == 0));
      chk("ringl_q8", q8, 8'(9'd1 << (c % 8)));
      chk("ringl_wrap8", 8'(wrap8), 8'(c == 8));
    end

    // Johnson right, 8 steps from the seed
    mode = 1'b1;
    dir = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      chk("johnr_q4", 8'(q4), 8'(exp_j[c]));
      chk("johnr_wrap4", 8'(wrap4), 8'(c == 7));
    end

    // Load an illegal value: held while idle, corrected on the next enable
    en = 1'b0;
    mode = 1'b0;
    load = 1'b1;
    load_val = 8'b0000_0101;
    cyc();
    load = 1'b0;
    chk("load_q4", 8'(q4), 8'b0101);
    chk("load_illegal4", 8'(illegal4), 8'd1);
    cyc();
    chk("load_hold_q4", 8'(q4), 8'b0101);
    en = 1'b1;
    cyc();
    chk("fix_q4", 8'(q4), 8'b0001);
    chk("fix_wrap4", 8'(wrap4), 8'd0);

    // Loading the seed does not pulse wrap
    en = 1'b0;
    load = 1'b1;
    load_val = 8'd1;
    cyc();
    load = 1'b0;
    chk("seedload_wrap4", 8'(wrap4), 8'd0);

    // Ring reaches 0100, then switch to Johnson: illegal, corrected, then Johnson left
    en = 1'b1;
    dir = 1'b0;
    repeat (2) cyc();
    chk("ring0100_q4", 8'(q4), 8'b0100);
    en = 1'b0;
    mode = 1'b1;
    #1;
    chk("switch_illegal4", 8'(illegal4), 8'd1);
    en = 1'b1;
    cyc();
    chk("switch_fix_q4", 8'(q4), 8'b0001);
    chk("switch_fix_wrap4", 8'(wrap4), 8'd0);
    cyc();
    chk("johnl_q4", 8'(q4), 8'b0011);

    // Back to ring: 0011 is corrected, then walk to 1000
    mode = 1'b0;
    cyc();
    chk("ringfix_q4", 8'(q4), 8'b0001);
    repeat (3) cyc();
    chk("ring1000_q4", 8'(q4), 8'b1000);

    // Asynchronous reset mid-cycle with en still high
    #2 rst_n = 1'b0;
    #1;
    chk("async_q4", 8'(q4), 8'b0001);
    chk("async_wrap4", 8'(wrap4), 8'd0);
    chk("async_q8", q8, 8'b0000_0001);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Ring right from the seed
    dir = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("ringr_q4", 8'(q4), 8'(9'd16 >> c));
      chk("ringr_wrap4", 8'(wrap4), 8'(c == 4));
    end

    en = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
